// File: rtl/rom_dl_arbiter.sv
// Shares one single-port ROM RAM between the data_io download writer and the core read port,
// and holds the core in reset until HOLD_CYCLES after a download ends. Optional checksum: ROM_DL_CHECKSUM_EN.
module rom_dl_arbiter #(
    parameter int          AW          = 16,
    parameter int unsigned ROM_SIZE    = 'hC000,
    parameter logic [7:0]  DL_INDEX    = 8'h00,
    parameter int          MEM_LAT     = 1,
    parameter int          HOLD_CYCLES = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dl_active,
    input  logic [7:0]    dl_index,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    output logic          core_ack,
    output logic [7:0]    core_rdata,
    output logic          core_reset,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [15:0]   dl_sum
);

    typedef enum logic [1:0] {ST_IDLE, ST_DL, ST_HOLD, ST_RUN} state_t;

    localparam logic [AW:0] ROM_LIMIT = (AW+1)'(ROM_SIZE);
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);
    localparam logic [1:0]  LAT_INIT  = 2'(MEM_LAT);

    state_t        state_q, state_d;
    logic [15:0]   hold_cnt_q, hold_cnt_d;
    logic          core_reset_q, core_reset_d;
    logic          busy_q, busy_d;
    logic [1:0]    lat_q, lat_d;
    logic          core_ack_q, core_ack_d;
    logic [7:0]    core_rdata_q, core_rdata_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;

    logic dl_hit;
    logic wr_ok;
    logic rd_en;

    assign dl_hit = dl_active && (dl_index == DL_INDEX);
    // A byte is taken on the cycle the download starts and on the cycle dl_active drops.
    assign wr_ok  = dl_wr && (dl_index == DL_INDEX) && ({1'b0, dl_addr} < ROM_LIMIT)
                    && (dl_hit || (state_q == ST_DL));
    assign rd_en  = (state_q == ST_RUN) && !dl_hit;

    always_comb begin
        // NOTE: every signal gets its default first so no path can infer a latch.
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        busy_d       = busy_q;
        lat_d        = lat_q;
        core_ack_d   = 1'b0;
        core_rdata_d = core_rdata_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: if (dl_hit) state_d = ST_DL;
            ST_DL: begin
                if (!dl_hit) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (dl_hit)                 state_d    = ST_DL;
                else if (hold_cnt_q == '0)  state_d    = ST_RUN;
                else                        hold_cnt_d = hold_cnt_q - 16'd1;
            end
            ST_RUN:  if (dl_hit) state_d = ST_DL;
            default: state_d = ST_IDLE;
        endcase

        core_reset_d = (state_d != ST_RUN);

        if (rd_en) begin
            if (busy_q) begin
                if (lat_q == '0) begin
                    core_ack_d   = 1'b1;
                    core_rdata_d = mem_rdata;
                    busy_d       = 1'b0;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end else if (core_req) begin
                busy_d     = 1'b1;
                lat_d      = LAT_INIT;
                mem_addr_d = core_addr;
            end
        end else begin
            // Leaving RUN (download start) silently drops any in-flight read.
            busy_d = 1'b0;
            lat_d  = '0;
        end

        if (wr_ok) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = dl_addr;
            mem_wdata_d = dl_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            lat_q        <= '0;
            core_ack_q   <= 1'b0;
            core_rdata_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of its peers.
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            lat_q        <= lat_d;
            core_ack_q   <= core_ack_d;
            core_rdata_q <= core_rdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign core_ack   = core_ack_q;
    assign core_rdata = core_rdata_q;
    assign core_reset = core_reset_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if ((state_q != ST_DL) && (state_d == ST_DL)) sum_d = '0;
        if (wr_ok) sum_d = sum_d + {8'h00, dl_data};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    assign dl_sum = sum_q;
`else
    assign dl_sum = 16'h0000;
`endif

endmodule
